fwft2_writer: RTL and testbench

Write-side companion of the two-word FWFT reader. Accepts double-width words from an upstream producer and writes them into a standard (non-FWFT) FIFO as two single-width words, upper half first. The word order therefore matches what the reader reassembles on the far side. The block sits between a producer of 2*dta_width data and the write port of a dta_width-wide FIFO, and provides a 4-half-word holding buffer plus registered backpressure.

---
 rtl/fwft2_writer.sv | 76 +++++++
 tb/tb_fwft2_writer.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/fwft2_writer.sv
// rtl/fwft2_writer.sv - splits double-width upstream words into upper/lower halves for a standard FIFO
// Optional sticky overflow detection is enabled by defining FWFT2_WRITER_OVERFLOW_EN.
module fwft2_writer #(
  parameter int dta_width = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clk_en,
  input  logic [2*dta_width-1:0]   din,
  input  logic                     wr_en,
  output logic                     full,
  output logic                     busy,
  output logic                     overflow,
  output logic [dta_width-1:0]     fifo_din,
  output logic                     fifo_wr_en,
  input  logic                     fifo_full
);

  logic [dta_width-1:0] slots [4];
  logic [1:0]           wr_ptr;
  logic [1:0]           rd_ptr;
  logic [2:0]           count;
  logic [2:0]           next_count;
  logic                 accept;
  logic                 drain;

  assign accept = clk_en & wr_en & ~full;
  assign drain  = clk_en & (count != 3'd0) & ~fifo_full;

  // Accept adds two half-words, a drain removes one; both together net +1.
  always_comb begin
    next_count = count;
    if (accept)
      next_count = next_count + 3'd2;
    if (drain)
      next_count = next_count - 3'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count  <= 3'd0;
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      full   <= 1'b0;
      for (int i = 0; i < 4; i++)
        slots[i] <= '0;
    end else if (clk_en) begin
      count <= next_count;
      // full is only low at count <= 2, so an accepted pair always fits.
      full  <= (next_count > 3'd2);
      if (drain)
        rd_ptr <= rd_ptr + 2'd1;
      if (accept) begin
        slots[wr_ptr]        <= din[2*dta_width-1:dta_width];
        slots[wr_ptr + 2'd1] <= din[dta_width-1:0];
        wr_ptr               <= wr_ptr + 2'd2;
      end
    end
  end

`ifdef FWFT2_WRITER_OVERFLOW_EN
  always_ff @(posedge clk) begin
    if (!rst)
      overflow <= 1'b0;
    else if (clk_en & wr_en & full)
      overflow <= 1'b1;
  end
`else
  assign overflow = 1'b0;
`endif

  assign busy       = (count != 3'd0);
  assign fifo_wr_en = drain;
  assign fifo_din   = slots[rd_ptr];

endmodule

// File: tb/tb_fwft2_writer.sv
// tb/tb_fwft2_writer.sv - directed and randomized bench for fwft2_writer against a queue-based model
module tb_fwft2_writer;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           clk_en = 1'b0;
  logic [2*W-1:0] din = '0;
  logic           wr_en = 1'b0;
  logic           full;
  logic           busy;
  logic           overflow;
  logic [W-1:0]   fifo_din;
  logic           fifo_wr_en;
  logic           fifo_full = 1'b0;

  fwft2_writer #(.dta_width(W)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .din(din), .wr_en(wr_en),
    .full(full), .busy(busy), .overflow(overflow),
    .fifo_din(fifo_din), .fifo_wr_en(fifo_wr_en), .fifo_full(fifo_full)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: the bytes still owed to the FIFO, in order, plus the backpressure and sticky flags.
  logic [W-1:0] q [$];
  logic         full_m = 1'b0;
  logic         ovf_m  = 1'b0;
  int           writes = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive, check comb/registered outputs against the model, advance both.
  task automatic cyc(input logic r, input logic ce, input logic we, input logic [2*W-1:0] d,
                     input logic ff, output logic acc);
    logic exp_wr;
    rst = r; clk_en = ce; wr_en = we; din = d; fifo_full = ff;
    #1;
    exp_wr = ce & (q.size() != 0) & ~ff;
    chk("busy", busy, q.size() != 0);
    chk("fifo_wr_en", fifo_wr_en, exp_wr);
    chk("full", full, full_m);
    chk("overflow", overflow, ovf_m);
    if (exp_wr)
      chk("fifo_din", fifo_din, q[0]);
    acc = r & ce & we & ~full_m;
    @(posedge clk);
    if (!r) begin
      q.delete();
      full_m = 1'b0;
      ovf_m  = 1'b0;
    end else if (ce) begin
      if (exp_wr) begin
        void'(q.pop_front());
        writes++;
      end
      if (acc) begin
        q.push_back(d[2*W-1:W]);
        q.push_back(d[W-1:0]);
      end
`ifdef FWFT2_WRITER_OVERFLOW_EN
      if (we & full_m)
        ovf_m = 1'b1;
`endif
      full_m = (q.size() > 2);
    end
    @(negedge clk);
  endtask

  initial begin
    logic       acc;
    int         k;
    logic [15:0] words [4];

    // Reset held for two edges while the producer is already pushing.
    @(negedge clk);
    rst = 1'b0; clk_en = 1'b1; wr_en = 1'b1; din = 16'hFFFF; fifo_full = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_full", full, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_fifo_wr_en", fifo_wr_en, 1'b0);
    chk("rst_overflow", overflow, 1'b0);
    chk("rst_fifo_din", fifo_din, 8'h00);
    cyc(1, 1, 0, 16'h0000, 0, acc);
    chk("rst_nothing_buffered", busy, 1'b0);

    // Single word: upper half in t+1, lower in t+2, idle after.
    cyc(1, 1, 1, 16'hA55A, 0, acc);
    chk("single_accept", acc, 1'b1);
    chk("single_upper", fifo_din, 8'hA5);
    cyc(1, 1, 0, 16'h0000, 0, acc);
    chk("single_lower", fifo_din, 8'h5A);
    cyc(1, 1, 0, 16'h0000, 0, acc);
    cyc(1, 1, 0, 16'h0000, 0, acc);

    // Streaming 0102, 0304, 0506 with wr_en held high.
    k = 0;
    for (int i = 0; i < 16; i++) begin
      cyc(1, 1, k < 3, {8'(2*k+1), 8'(2*k+2)}, 0, acc);
      if (acc) k++;
    end
    chk("stream_words", k, 3);

    // Stall: FIFO full while two words arrive, then overflow attempt, then release.
    words[0] = 16'h1122; words[1] = 16'h3344;
    k = 0;
    for (int i = 0; i < 4; i++) begin
      cyc(1, 1, k < 2, words[k < 2 ? k : 1], 1, acc);
      if (acc) k++;
    end
    chk("stall_accepts", k, 2);
    chk("stall_full", full, 1'b1);
    cyc(1, 1, 1, 16'hDEAD, 1, acc);
    chk("ovf_discard", acc, 1'b0);
    for (int i = 0; i < 6; i++)
      cyc(1, 1, 0, 16'h0000, 0, acc);
    chk("stall_drained", busy, 1'b0);

    // clk_en low mid-drain, including discarded writes while frozen.
    words[2] = 16'h5566; words[3] = 16'h7788;
    cyc(1, 1, 1, words[2], 0, acc);
    cyc(1, 1, 1, words[3], 0, acc);
    for (int i = 0; i < 3; i++)
      cyc(1, 0, 1, 16'hBEEF, 0, acc);
    for (int i = 0; i < 6; i++)
      cyc(1, 1, 0, 16'h0000, 0, acc);

    // Reset mid-drain flushes everything.
    cyc(1, 1, 1, 16'hCAFE, 0, acc);
    cyc(1, 1, 1, 16'hF00D, 0, acc);
    cyc(0, 1, 0, 16'h0000, 0, acc);
    for (int i = 0; i < 4; i++)
      cyc(1, 1, 0, 16'h0000, 0, acc);
    chk("flush_busy", busy, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 600; i++)
      cyc($urandom_range(0, 99) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
          16'($urandom), $urandom_range(0, 2) == 0, acc);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
